// File: rtl/mig_ui_pkg.sv
// Shared constants and helpers for the MIG 7-series UI behavioural model.
package mig_ui_pkg;
  localparam int UI_DW = 128;
  localparam int UI_MW = 16;
  localparam int UI_AW = 27;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // app_addr counts 16-bit units and a 128-bit word holds eight of them
  function automatic logic [UI_AW-4:0] word_index(input logic [UI_AW-1:0] addr);
    return addr[UI_AW-1:3];
  endfunction
endpackage

// File: rtl/ui_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; head is shown on dout.
module ui_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mig_ui_model.sv
// Behavioural MIG 7-series DDR2 UI: in-order command execution against an
// internal 128-bit array, fixed read latency, fake calibration and maintenance.
module mig_ui_model
  import mig_ui_pkg::*;
#(
  parameter int MEM_AW       = 10,
  parameter int CALIB_CYCLES = 16,
  parameter int READ_LATENCY = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst,
  input  logic [UI_AW-1:0] app_addr,
  input  logic [2:0]       app_cmd,
  input  logic             app_en,
  input  logic [UI_DW-1:0] app_wdf_data,
  input  logic             app_wdf_end,
  input  logic [UI_MW-1:0] app_wdf_mask,
  input  logic             app_wdf_wren,
  input  logic             app_sr_req,
  input  logic             app_ref_req,
  input  logic             app_zq_req,
  output logic [UI_DW-1:0] app_rd_data,
  output logic             app_rd_data_valid,
  output logic             app_rd_data_end,
  output logic             app_rdy,
  output logic             app_wdf_rdy,
  output logic             app_sr_active,
  output logic             app_ref_ack,
  output logic             app_zq_ack,
  output logic             ui_clk,
  output logic             ui_clk_sync_rst,
  output logic             init_calib_complete
);
  localparam int CMD_W = 3 + MEM_AW;
  localparam int DAT_W = UI_MW + UI_DW;
  localparam int CW    = $clog2(CALIB_CYCLES + 1);

  logic [1:0]        rst_sync;
  logic [CW-1:0]     cal_cnt;
  logic [UI_AW-4:0]  widx;
  logic              cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic              dat_push, dat_pop, dat_full, dat_empty;
  logic [CMD_W-1:0]  cmd_head;
  logic [DAT_W-1:0]  dat_head;
  logic [2:0]        head_cmd;
  logic [MEM_AW-1:0] head_idx;
  logic              exec_rd, exec_wr;
  logic [UI_DW-1:0]  mem [2**MEM_AW];
  logic [READ_LATENCY:1] vld_pipe;
  logic [UI_DW-1:0]  dat_pipe [1:READ_LATENCY];
  logic [1:0]        mnt_req, mnt_p1, mnt_p2, mnt_ack;
  logic              unused_ok;

  assign ui_clk          = sys_clk_i;
  assign ui_clk_sync_rst = rst_sync[1];
  assign app_sr_active   = 1'b0;
  assign unused_ok       = &{1'b0, app_wdf_end, app_sr_req, app_addr[2:0], widx[UI_AW-4:MEM_AW]};

  always_ff @(posedge sys_clk_i or negedge sys_rst) begin
    if (!sys_rst) rst_sync <= 2'b11;
    else          rst_sync <= {rst_sync[0], 1'b0};
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst) begin
    if (!sys_rst) begin
      cal_cnt             <= '0;
      init_calib_complete <= 1'b0;
    end else if (!ui_clk_sync_rst && !init_calib_complete) begin
      if (cal_cnt == CW'(CALIB_CYCLES - 1)) init_calib_complete <= 1'b1;
      else                                  cal_cnt <= cal_cnt + 1'b1;
    end
  end

  assign app_rdy     = init_calib_complete & ~cmd_full;
  assign app_wdf_rdy = init_calib_complete & ~dat_full;
  assign widx        = word_index(app_addr);
  assign cmd_push    = app_en & app_rdy;
  assign dat_push    = app_wdf_wren & app_wdf_rdy;

  ui_sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk(sys_clk_i), .rst_n(sys_rst), .push(cmd_push), .pop(cmd_pop),
    .din({app_cmd, widx[MEM_AW-1:0]}), .dout(cmd_head), .full(cmd_full), .empty(cmd_empty)
  );

  ui_sync_fifo #(.WIDTH(DAT_W), .DEPTH(FIFO_DEPTH)) u_dat_fifo (
    .clk(sys_clk_i), .rst_n(sys_rst), .push(dat_push), .pop(dat_pop),
    .din({app_wdf_mask, app_wdf_data}), .dout(dat_head), .full(dat_full), .empty(dat_empty)
  );

  // A write at the head with no data yet blocks everything behind it
  assign head_cmd = cmd_head[CMD_W-1 -: 3];
  assign head_idx = cmd_head[MEM_AW-1:0];
  assign exec_rd  = ~cmd_empty & (head_cmd == CMD_READ);
  assign exec_wr  = ~cmd_empty & (head_cmd == CMD_WRITE) & ~dat_empty;
  assign cmd_pop  = ~cmd_empty & ((head_cmd != CMD_WRITE) | ~dat_empty);
  assign dat_pop  = exec_wr;

  // Array contents deliberately survive reset
  always_ff @(posedge sys_clk_i)
    if (exec_wr)
      for (int b = 0; b < UI_MW; b++)
        if (!dat_head[UI_DW+b]) mem[head_idx][8*b +: 8] <= dat_head[8*b +: 8];

  always_ff @(posedge sys_clk_i or negedge sys_rst) begin
    if (!sys_rst) begin
      vld_pipe <= '0;
      for (int i = 1; i <= READ_LATENCY; i++) dat_pipe[i] <= '0;
    end else begin
      vld_pipe[1] <= exec_rd;
      if (exec_rd) dat_pipe[1] <= mem[head_idx];
      // data stages only load behind a valid, so the output holds its last read
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign app_rd_data       = dat_pipe[READ_LATENCY];
  assign app_rd_data_valid = vld_pipe[READ_LATENCY];
  assign app_rd_data_end   = vld_pipe[READ_LATENCY];

  // bit 0 = refresh, bit 1 = ZQ; a request while p1/p2 is pending is merged
  assign mnt_req = {app_zq_req, app_ref_req};

  always_ff @(posedge sys_clk_i or negedge sys_rst) begin
    if (!sys_rst) begin
      mnt_p1  <= '0;
      mnt_p2  <= '0;
      mnt_ack <= '0;
    end else begin
      mnt_p1  <= mnt_req & ~mnt_p1 & ~mnt_p2;
      mnt_p2  <= mnt_p1;
      mnt_ack <= mnt_p2;
    end
  end

  assign app_ref_ack = mnt_ack[0];
  assign app_zq_ack  = mnt_ack[1];
endmodule

// File: tb/tb_mig_ui_model.sv
// Randomised + directed bench for mig_ui_model with a queue-based reference model.
module tb_mig_ui_model;
  import mig_ui_pkg::*;

  localparam int MEM_AW = 10;
  localparam int CAL    = 16;
  localparam int LAT    = 4;
  localparam int DEPTH  = 4;
  localparam logic [127:0] PAT = 128'h0123456789ABCDEF0123456789ABCDEF;

  logic         clk = 1'b0;
  logic         sys_rst;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_wdf_end, app_wdf_wren, app_sr_req, app_ref_req, app_zq_req;
  logic [127:0] app_wdf_data, app_rd_data;
  logic [15:0]  app_wdf_mask;
  logic         app_rd_data_valid, app_rd_data_end, app_rdy, app_wdf_rdy, app_sr_active;
  logic         app_ref_ack, app_zq_ack, ui_clk, ui_clk_sync_rst, init_calib_complete;

  always #5 clk = ~clk;

  mig_ui_model #(.MEM_AW(MEM_AW), .CALIB_CYCLES(CAL), .READ_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk_i(clk), .sys_rst(sys_rst), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_sr_req(app_sr_req), .app_ref_req(app_ref_req),
    .app_zq_req(app_zq_req), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_sr_active(app_sr_active), .app_ref_ack(app_ref_ack), .app_zq_ack(app_zq_ack),
    .ui_clk(ui_clk), .ui_clk_sync_rst(ui_clk_sync_rst), .init_calib_complete(init_calib_complete)
  );

  typedef struct { logic [2:0] cmd; int w; } mcmd_t;
  typedef struct { logic [127:0] d; logic [15:0] m; } mdat_t;

  mcmd_t        mcmd[$];
  mdat_t        mdat[$];
  logic [127:0] exp_q[$];
  logic [127:0] ref_mem [int];
  int           checks = 0, failures = 0;
  bit           acc_c, acc_d;

  task automatic chk(string name, logic [127:0] act, logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // In-order semantics: a write needs a data beat, reads see all earlier writes
  task automatic model_run();
    mdat_t d;
    logic [127:0] v;
    while (mcmd.size() > 0) begin
      if (mcmd[0].cmd == CMD_WRITE) begin
        if (mdat.size() == 0) break;
        d = mdat.pop_front();
        v = ref_mem.exists(mcmd[0].w) ? ref_mem[mcmd[0].w] : 'x;
        for (int b = 0; b < 16; b++) if (!d.m[b]) v[8*b +: 8] = d.d[8*b +: 8];
        ref_mem[mcmd[0].w] = v;
      end else if (mcmd[0].cmd == CMD_READ) begin
        exp_q.push_back(ref_mem.exists(mcmd[0].w) ? ref_mem[mcmd[0].w] : 'x);
      end
      void'(mcmd.pop_front());
    end
  endtask

  // Inputs are set at a negedge; acceptance is decided from pre-edge ready
  task automatic tick();
    #1;
    acc_c = app_en && app_rdy;
    acc_d = app_wdf_wren && app_wdf_rdy;
    if (acc_c) mcmd.push_back('{app_cmd, int'(app_addr[MEM_AW+2:3])});
    if (acc_d) mdat.push_back('{app_wdf_data, app_wdf_mask});
    model_run();
    @(negedge clk);
  endtask

  function automatic logic [26:0] mkaddr(int w);
    logic [13:0] hi;
    logic [2:0]  lo;
    hi = 14'($urandom);
    lo = 3'($urandom);
    return {hi, w[9:0], lo};
  endfunction

  function automatic int pick_w();
    int r;
    r = $urandom_range(0, 16);
    return (r == 16) ? 1023 : r;
  endfunction

  task automatic idle(int n);
    app_en = 1'b0;
    app_wdf_wren = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wr_full(int w, logic [127:0] d, logic [15:0] m);
    int n;
    n = 0;
    app_en = 1'b1; app_cmd = CMD_WRITE; app_addr = mkaddr(w);
    app_wdf_wren = 1'b1; app_wdf_data = d; app_wdf_mask = m;
    while ((app_en || app_wdf_wren) && n < 20) begin
      tick();
      n++;
      if (acc_c) app_en = 1'b0;
      if (acc_d) app_wdf_wren = 1'b0;
    end
    chk("wr_accept", {app_en, app_wdf_wren}, 0);
    app_en = 1'b0;
    app_wdf_wren = 1'b0;
  endtask

  task automatic read_direct(int w, logic [127:0] e, string name);
    int n;
    idle(6);
    app_en = 1'b1; app_cmd = CMD_READ; app_addr = mkaddr(w);
    tick();
    app_en = 1'b0;
    chk({name, "_acc"}, acc_c, 1);
    n = 0;
    while (!app_rd_data_valid && n < 20) begin tick(); n++; end
    chk({name, "_lat"}, n, LAT);
    chk({name, "_data"}, app_rd_data, e);
    tick();
    chk({name, "_pulse"}, app_rd_data_valid, 0);
  endtask

  // Scoreboard monitor: every returned beat must match the oldest expectation
  always @(negedge clk) begin
    if (sys_rst === 1'b1 && app_rd_data_valid) begin
      chk("rd_end", app_rd_data_end, 1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got read data %0h expected no read", app_rd_data);
      end else begin
        chk("sb_data", app_rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, vcnt, pulses;
    logic [127:0] dk [5];
    int wl [5];

    sys_rst = 1'b0; app_addr = '0; app_cmd = '0; app_en = 1'b0; app_wdf_end = 1'b0;
    app_wdf_data = '0; app_wdf_mask = '0; app_wdf_wren = 1'b0;
    app_sr_req = 1'b0; app_ref_req = 1'b0; app_zq_req = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_ui_rst", ui_clk_sync_rst, 1);
    chk("rst_calib", init_calib_complete, 0);
    chk("rst_rdy", {app_rdy, app_wdf_rdy}, 0);
    chk("rst_rd", {app_rd_data_valid, app_rd_data_end, app_rd_data}, 0);
    chk("rst_acks", {app_ref_ack, app_zq_ack, app_sr_active}, 0);

    // calibration: traffic offered throughout must not be accepted
    sys_rst = 1'b1;
    app_en = 1'b1; app_cmd = CMD_READ; app_addr = mkaddr(0);
    app_wdf_wren = 1'b1; app_wdf_data = {4{$urandom}};
    for (int k = 1; k <= CAL + 4; k++) begin
      tick();
      chk($sformatf("cal_ui_rst_%0d", k), ui_clk_sync_rst, k < 2);
      chk($sformatf("cal_done_%0d", k), init_calib_complete, k >= CAL + 2);
      chk($sformatf("cal_rdy_%0d", k), {app_rdy, app_wdf_rdy}, (k >= CAL + 2) ? 2'b11 : 2'b00);
      if (k == CAL + 1) begin app_en = 1'b0; app_wdf_wren = 1'b0; end
    end

    for (int w = 0; w <= 16; w++) wr_full((w == 16) ? 1023 : w, {4{$urandom}}, 16'h0);

    // basic write/read and an independent word
    wr_full(0, PAT, 16'h0);
    read_direct(0, PAT, "rd_pat");
    read_direct(2, ref_mem[2], "rd_w2");

    // byte mask: upper 8 bytes written
    wr_full(2, '0, 16'h0);
    wr_full(2, '1, 16'h00FF);
    read_direct(2, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, "rd_mask");

    // stall: five write commands, no data
    wl = '{5, 6, 7, 5, 8};
    for (int k = 0; k < 5; k++) dk[k] = {4{32'hA5A5_0000 + 32'(k)}};
    idle(4);
    n = 0;
    app_en = 1'b1; app_cmd = CMD_WRITE;
    for (int c = 0; c < 10 && n < 4; c++) begin
      app_addr = mkaddr(wl[n]);
      tick();
      if (acc_c) n++;
    end
    chk("stall_acc4", n, 4);
    chk("stall_rdy_lo", app_rdy, 0);
    app_addr = mkaddr(wl[4]);
    repeat (3) begin
      tick();
      chk("stall_no_acc", acc_c, 0);
    end
    vcnt = 0;
    app_wdf_wren = 1'b1; app_wdf_mask = '0; app_wdf_data = dk[0];
    for (int c = 0; c < 30 && (app_en || app_wdf_wren); c++) begin
      tick();
      if (acc_c) begin n++; app_en = 1'b0; end
      if (acc_d) begin
        vcnt++;
        if (vcnt == 5) app_wdf_wren = 1'b0; else app_wdf_data = dk[vcnt];
      end
    end
    chk("stall_all_acc", {n, vcnt}, {32'd5, 32'd5});
    idle(4);
    chk("stall_rdy_back", {app_rdy, app_wdf_rdy}, 2'b11);
    read_direct(5, dk[3], "rd_order5");
    read_direct(6, dk[1], "rd_order6");
    read_direct(8, dk[4], "rd_order8");

    // reset with two reads in flight
    idle(4);
    app_en = 1'b1; app_cmd = CMD_READ; app_addr = mkaddr(0);
    tick();
    app_addr = mkaddr(2);
    tick();
    app_en = 1'b0;
    tick();
    sys_rst = 1'b0;
    #1;
    chk("mid_rst_state", {ui_clk_sync_rst, init_calib_complete, app_rdy, app_rd_data_valid}, 4'b1000);
    exp_q.delete(); mcmd.delete(); mdat.delete();
    repeat (3) @(negedge clk);
    sys_rst = 1'b1;
    n = 0; vcnt = 0;
    while (!init_calib_complete && n < 40) begin tick(); n++; vcnt += app_rd_data_valid; end
    chk("recal_edges", n, CAL + 2);
    repeat (8) begin tick(); vcnt += app_rd_data_valid; end
    chk("rst_drop_reads", vcnt, 0);
    read_direct(0, PAT, "rd_after_rst");

    // maintenance
    idle(3);
    app_sr_req = 1'b1; app_ref_req = 1'b1; app_zq_req = 1'b1;
    tick();
    app_ref_req = 1'b0; app_zq_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ack_ref_%0d", k), app_ref_ack, k == 2);
      chk($sformatf("ack_zq_%0d", k), app_zq_ack, k == 2);
      chk("sr_active", app_sr_active, 0);
      tick();
    end
    app_sr_req = 1'b0;
    app_ref_req = 1'b1;
    repeat (2) tick();
    app_ref_req = 1'b0;
    pulses = app_ref_ack;
    repeat (6) begin tick(); pulses += app_ref_ack; end
    chk("ack_merge", pulses, 1);

    // random traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      n = $urandom_range(0, 9);
      app_en       = 1'($urandom_range(0, 1));
      app_cmd      = (n < 4) ? CMD_WRITE : (n < 8) ? CMD_READ : 3'($urandom_range(2, 7));
      app_addr     = mkaddr(pick_w());
      app_wdf_wren = 1'($urandom_range(0, 1));
      app_wdf_end  = 1'($urandom_range(0, 1));
      app_wdf_data = {$urandom, $urandom, $urandom, $urandom};
      app_wdf_mask = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      tick();
    end
    app_en = 1'b0;
    n = 0;
    while (mcmd.size() > 0 && n < 200) begin
      app_wdf_wren = 1'b1;
      app_wdf_data = {$urandom, $urandom, $urandom, $urandom};
      app_wdf_mask = '0;
      tick();
      n++;
    end
    app_wdf_wren = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin tick(); n++; end
    chk("drain_cmds", mcmd.size(), 0);
    chk("drain_reads", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
